// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between two requesters: port 0 is
//            the EX-stage integer path, port 1 the branch/address-compare
//            path. Round-robin grant, operand steering, and a per-port
//            registered response slot with one cycle of latency.
// Options  : define ALU_ARB_PERF_CNT_EN to add grant and conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*OP_WIDTH-1:0]   req_op,
  input  logic [2*DATA_WIDTH-1:0] req_a,
  input  logic [2*DATA_WIDTH-1:0] req_b,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [2*DATA_WIDTH-1:0] resp_result,
  output logic [5:0]              resp_flags,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [OP_WIDTH-1:0]     alu_op,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_overflow,
  input  logic                    alu_carryout,
  input  logic                    alu_zero
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [31:0]             grant_cnt0,
  output logic [31:0]             grant_cnt1,
  output logic [31:0]             conflict_cnt
`endif
);

  logic [1:0]              r_resp_valid;
  logic [2*DATA_WIDTH-1:0] r_resp_result;
  logic [5:0]              r_resp_flags;
  logic                    r_rr_ptr;

  logic [1:0] w_free;
  logic [1:0] w_elig;
  logic       w_both;
  logic [1:0] w_gnt;
  logic       w_sel;

  // A slot is free when empty or being drained this cycle; nothing is
  // eligible while reset is held so requests during reset are never taken.
  assign w_free = ~r_resp_valid | resp_ready;
  assign w_elig = rst ? 2'b00 : (req_valid & w_free);
  assign w_both = &w_elig;
  assign w_sel  = w_gnt[1];

  // Round-robin grant: pointer decides only when both ports contend.
  always_comb begin
    w_gnt = w_elig;
    if (w_both) begin
      w_gnt = r_rr_ptr ? 2'b10 : 2'b01;
    end
  end

  assign req_ready   = w_gnt;
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign resp_flags  = r_resp_flags;

  // Steer the granted port onto the ALU; idle ALU sees AND 0,0.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (|w_gnt) begin
      alu_a  = w_sel ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
      alu_b  = w_sel ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
      alu_op = w_sel ? req_op[2*OP_WIDTH-1:OP_WIDTH]    : req_op[OP_WIDTH-1:0];
    end
  end

  generate
    for (genvar i = 0; i < 2; i++) begin : g_port
      // Response slot: capture on grant, otherwise clear once consumed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_resp_valid[i]                          <= 1'b0;
          r_resp_result[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
          r_resp_flags[i*3 +: 3]                    <= 3'b000;
        end else if (w_gnt[i]) begin
          r_resp_valid[i]                          <= 1'b1;
          r_resp_result[i*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
          r_resp_flags[i*3 +: 3]                    <= {alu_overflow, alu_carryout, alu_zero};
        end else if (resp_ready[i]) begin
          r_resp_valid[i]                          <= 1'b0;
        end
      end
    end
  endgenerate

  // Pointer moves to the losing port only after a contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_both) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0] r_grant_cnt0;
  logic [31:0] r_grant_cnt1;
  logic [31:0] r_conflict_cnt;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt0   <= '0;
      r_grant_cnt1   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt[0]) r_grant_cnt0   <= r_grant_cnt0 + 32'd1;
      if (w_gnt[1]) r_grant_cnt1   <= r_grant_cnt1 + 32'd1;
      if (w_both)   r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign grant_cnt0   = r_grant_cnt0;
  assign grant_cnt1   = r_grant_cnt1;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter with a
//            behavioural ALU model closing the loop on the ALU ports.
//            Counter checks compile in when ALU_ARB_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*OW-1:0] req_op;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [1:0]    resp_valid;
  logic [1:0]    resp_ready;
  logic [2*DW-1:0] resp_result;
  logic [5:0]    resp_flags;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_result;
  logic          alu_overflow;
  logic          alu_carryout;
  logic          alu_zero;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0]   grant_cnt0;
  logic [31:0]   grant_cnt1;
  logic [31:0]   conflict_cnt;
`endif

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_flags   (resp_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_carryout (alu_carryout),
    .alu_zero     (alu_zero)
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: flags are {Overflow, CarryOut, Zero}; carry on SUB is borrow.
  logic [32:0] m_sum;
  logic [31:0] m_res;
  logic        m_ov;
  logic        m_co;
  always_comb begin
    m_sum = '0;
    m_res = 32'hDEAD_BEEF;
    m_ov  = 1'b0;
    m_co  = 1'b0;
    case (alu_op)
      4'h0: m_res = alu_a & alu_b;
      4'h1: m_res = alu_a | alu_b;
      4'h2: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_res = m_sum[31:0];
        m_co  = m_sum[32];
        m_ov  = (alu_a[31] == alu_b[31]) && (m_sum[31] != alu_a[31]);
      end
      4'h3: m_res = {alu_b[15:0], 16'h0000};
      4'h4: m_res = {31'd0, (alu_a < alu_b)};
      4'h5: m_res = alu_b << alu_a[4:0];
      4'h6: begin
        m_res = alu_a - alu_b;
        m_co  = (alu_a < alu_b);
        m_ov  = (alu_a[31] != alu_b[31]) && ((alu_a[31] ^ alu_b[31] ^ 1'b1) == 1'b0)
                && (((alu_a - alu_b) >> 31) != {31'd0, alu_a[31]});
      end
      4'h7: m_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      4'h9: m_res = ~(alu_a | alu_b);
      4'hA: m_res = alu_a ^ alu_b;
      4'hB: m_res = $signed(alu_b) >>> alu_a[4:0];
      4'hC: m_res = alu_b >> alu_a[4:0];
      default: m_res = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_result   = m_res;
  assign alu_overflow = m_ov;
  assign alu_carryout = m_co;
  assign alu_zero     = (m_res == 32'd0);

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[p*OW +: OW] = op;
    req_a[p*DW +: DW]  = a;
    req_b[p*DW +: DW]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 2'b00;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    set_port(0, 4'h2, 32'd5, 32'd7);
    set_port(1, 4'h4, 32'd1, 32'd2);

    // Reset state with requests presented
    mid();
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
    chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
    chk("rst_resp_result", resp_result, 64'd0);
    tick();
    rst = 1'b0;

    // Port 0 only: ADD 5+7
    req_valid  = 2'b01;
    resp_ready = 2'b11;
    mid();
    chk("p0_req_ready", {62'd0, req_ready}, 64'h1);
    chk("p0_alu_a", {32'd0, alu_a}, 64'd5);
    chk("p0_alu_b", {32'd0, alu_b}, 64'd7);
    chk("p0_alu_op", {60'd0, alu_op}, 64'h2);
    tick();
    chk("p0_resp_valid", {62'd0, resp_valid}, 64'h1);
    chk("p0_result", {32'd0, resp_result[31:0]}, 64'd12);
    chk("p0_flags", {61'd0, resp_flags[2:0]}, 64'h0);
    req_valid = 2'b00;
    mid();
    chk("idle_req_ready", {62'd0, req_ready}, 64'h0);
    chk("idle_alu_a", {32'd0, alu_a}, 64'd0);
    tick();
    chk("idle_drained", {62'd0, resp_valid}, 64'h0);

    // Both ports contend: grants alternate 0,1,0
    set_port(0, 4'h6, 32'd3, 32'd3);
    set_port(1, 4'h4, 32'd1, 32'd2);
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("dual_req_ready", {62'd0, req_ready}, (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      if (i % 2 == 0) begin
        chk("dual_valid0", {62'd0, resp_valid}, 64'h1);
        chk("dual_result0", {32'd0, resp_result[31:0]}, 64'd0);
        chk("dual_flags0", {61'd0, resp_flags[2:0]}, 64'h1);
      end else begin
        chk("dual_valid1", {62'd0, resp_valid}, 64'h2);
        chk("dual_result1", {32'd0, resp_result[63:32]}, 64'd1);
        chk("dual_flags1", {61'd0, resp_flags[5:3]}, 64'h0);
      end
    end

    // Port 1 alone: single grant leaves pointer at port 1
    req_valid = 2'b10;
    mid();
    chk("p1_req_ready", {62'd0, req_ready}, 64'h2);
    tick();
    chk("p1_resp_valid", {62'd0, resp_valid}, 64'h2);
    chk("p1_result", {32'd0, resp_result[63:32]}, 64'd1);

    // Port 1 backpressured: port 0 owns the ALU, port 1 result held
    resp_ready = 2'b01;
    req_valid  = 2'b11;
    set_port(0, 4'h2, 32'd10, 32'd20);
    set_port(1, 4'h4, 32'd5, 32'd2);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("hold_req_ready", {62'd0, req_ready}, 64'h1);
      tick();
      chk("hold_resp_valid", {62'd0, resp_valid}, 64'h3);
      chk("hold_result1", {32'd0, resp_result[63:32]}, 64'd1);
      chk("hold_result0", {32'd0, resp_result[31:0]}, 64'd30);
    end

    // Release: port 1 drains and refills in the same cycle
    resp_ready = 2'b11;
    mid();
    chk("release_req_ready", {62'd0, req_ready}, 64'h2);
    tick();
    chk("release_valid", {62'd0, resp_valid}, 64'h2);
    chk("release_result1", {32'd0, resp_result[63:32]}, 64'd0);
    chk("release_flags1", {61'd0, resp_flags[5:3]}, 64'h1);

    // Signed overflow on port 0
    req_valid = 2'b01;
    set_port(0, 4'h2, 32'h7FFF_FFFF, 32'h0000_0001);
    mid();
    chk("ovf_req_ready", {62'd0, req_ready}, 64'h1);
    tick();
    chk("ovf_valid", {62'd0, resp_valid}, 64'h1);
    chk("ovf_result", {32'd0, resp_result[31:0]}, 64'h8000_0000);
    chk("ovf_flags", {61'd0, resp_flags[2:0]}, 64'h4);

    // Undefined opcode passes through untouched
    set_port(0, 4'hF, 32'd9, 32'd3);
    mid();
    chk("undef_alu_op", {60'd0, alu_op}, 64'hF);
    tick();
    chk("undef_result", {32'd0, resp_result[31:0]}, 64'hDEAD_BEEF);

    // Reset one cycle after a contended grant
    req_valid = 2'b11;
    set_port(0, 4'h2, 32'd1, 32'd1);
    set_port(1, 4'h4, 32'd1, 32'd2);
    mid();
    chk("pre_rst_req_ready", {62'd0, req_ready}, 64'h1);
    tick();
    chk("pre_rst_valid", {62'd0, resp_valid}, 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {62'd0, resp_valid}, 64'h0);
    chk("mid_rst_result", resp_result, 64'd0);
    chk("mid_rst_req_ready", {62'd0, req_ready}, 64'h0);
    chk("mid_rst_alu_a", {32'd0, alu_a}, 64'd0);
    tick();
    rst = 1'b0;
    mid();
    chk("post_rst_req_ready", {62'd0, req_ready}, 64'h1);
    tick();
    chk("post_rst_valid", {62'd0, resp_valid}, 64'h1);
    chk("post_rst_result0", {32'd0, resp_result[31:0]}, 64'd2);

`ifdef ALU_ARB_PERF_CNT_EN
    // Counters over ten contended cycles
    rst = 1'b1;
    tick();
    chk("cnt_rst_grant0", {32'd0, grant_cnt0}, 64'd0);
    chk("cnt_rst_conflict", {32'd0, conflict_cnt}, 64'd0);
    rst = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    repeat (10) tick();
    req_valid = 2'b00;
    chk("cnt_grant0", {32'd0, grant_cnt0}, 64'd5);
    chk("cnt_grant1", {32'd0, grant_cnt1}, 64'd5);
    chk("cnt_conflict", {32'd0, conflict_cnt}, 64'd10);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
